// File: rtl/approx_div_pkg.sv
// Shared definitions for the sequential 16/8 restoring divider.
//   state_e    : controller states IDLE / CALC / DONE
//   DIVIDEND_W : dividend (product) width
//   DIVISOR_W  : divisor, remainder and partial-remainder base width
//   Q_W        : quotient width
//   CNT_W      : iteration counter width
// Optional feature macro: APPROX_DIV_TRUNC_EN (consumed by approx_div_16x8_seq).
package approx_div_pkg;

  localparam int unsigned DIVIDEND_W = 16;
  localparam int unsigned DIVISOR_W  = 8;
  localparam int unsigned Q_W        = 8;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/approx_div_step.sv
// One combinational restoring-division iteration.
// Ports:
//   PR      in  9  current partial remainder (always < divisor)
//   din     in  1  next dividend bit shifted in at the bottom
//   B       in  8  divisor
//   PR_next out 9  partial remainder after the conditional subtract
//   qbit    out 1  quotient bit produced by this iteration
module approx_div_step
  import approx_div_pkg::*;
(
  input  logic [DIVISOR_W:0]   PR,
  input  logic                 din,
  input  logic [DIVISOR_W-1:0] B,
  output logic [DIVISOR_W:0]   PR_next,
  output logic                 qbit
);

  logic [DIVISOR_W:0] w_shift;
  logic               w_ge;

  assign w_shift = {PR[DIVISOR_W-1:0], din};
  assign w_ge    = (w_shift >= {1'b0, B});

  // A set PR msb means the shifted value is at least 512, above any divisor; the 9-bit
  // wrap-around subtraction below still yields the correct (small) remainder.
  assign qbit    = PR[DIVISOR_W] | w_ge;
  assign PR_next = qbit ? (w_shift - {1'b0, B}) : w_shift;

endmodule

// File: rtl/approx_div_16x8_seq.sv
// Sequential restoring divider: 16-bit dividend R / 8-bit divisor B -> 8-bit Q, 8-bit REM.
// One restoring iteration per clock, valid/ready handshake on both sides.
// Optional feature macro: APPROX_DIV_TRUNC_EN -- when defined, only 8-TRUNC_BITS iterations
// run, the low TRUNC_BITS quotient bits are forced to zero and REM reads zero.
// Ports:
//   clk       in   1   rising-edge clock
//   rst_n     in   1   asynchronous active-low reset
//   in_valid  in   1   operand request valid
//   in_ready  out  1   idle, operands accepted this cycle if in_valid
//   R         in   16  dividend
//   B         in   8   divisor
//   out_valid out  1   result valid, held until out_ready
//   out_ready in   1   consumer takes the result
//   Q         out  8   quotient
//   REM       out  8   remainder
//   ovf       out  1   quotient does not fit in 8 bits
//   dbz       out  1   divide by zero
module approx_div_16x8_seq
  import approx_div_pkg::*;
#(
  parameter int unsigned TRUNC_BITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] R,
  input  logic [DIVISOR_W-1:0]  B,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [Q_W-1:0]        Q,
  output logic [DIVISOR_W-1:0]  REM,
  output logic                  ovf,
  output logic                  dbz
);

`ifdef APPROX_DIV_TRUNC_EN
  localparam int unsigned NIter = Q_W - TRUNC_BITS;
`else
  // TRUNC_BITS has no effect in the exact build.
  localparam int unsigned NIter = Q_W + 0 * TRUNC_BITS;
`endif
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(NIter - 1);

  state_e               r_state, w_state_nxt;
  logic [DIVISOR_W:0]   r_pr, w_pr_nxt;
  logic [DIVISOR_W-1:0] r_d, w_d_nxt;
  logic [DIVISOR_W-1:0] r_b, w_b_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [Q_W-1:0]       r_q, w_q_nxt;
  logic [DIVISOR_W-1:0] r_rem, w_rem_nxt;
  logic                 r_ovf, w_ovf_nxt;
  logic                 r_dbz, w_dbz_nxt;

  logic [DIVISOR_W:0]   w_step_pr;
  logic                 w_qbit;
  logic [Q_W-1:0]       w_q_shift;

  approx_div_step u_step (
    .PR      (r_pr),
    .din     (r_d[DIVISOR_W-1]),
    .B       (r_b),
    .PR_next (w_step_pr),
    .qbit    (w_qbit)
  );

  assign w_q_shift = {r_q[Q_W-2:0], w_qbit};

  always_comb begin
    w_state_nxt = r_state;
    w_pr_nxt    = r_pr;
    w_d_nxt     = r_d;
    w_b_nxt     = r_b;
    w_cnt_nxt   = r_cnt;
    w_q_nxt     = r_q;
    w_rem_nxt   = r_rem;
    w_ovf_nxt   = r_ovf;
    w_dbz_nxt   = r_dbz;
    unique case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_cnt_nxt = '0;
          w_ovf_nxt = 1'b0;
          w_dbz_nxt = 1'b0;
          if (B == '0) begin
            w_q_nxt     = '1;
            w_rem_nxt   = R[DIVISOR_W-1:0];
            w_dbz_nxt   = 1'b1;
            w_state_nxt = DONE;
          end else if (R[DIVIDEND_W-1:DIVISOR_W] >= B) begin
            w_q_nxt     = '1;
            w_rem_nxt   = '0;
            w_ovf_nxt   = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_pr_nxt    = {1'b0, R[DIVIDEND_W-1:DIVISOR_W]};
            w_d_nxt     = R[DIVISOR_W-1:0];
            w_b_nxt     = B;
            w_q_nxt     = '0;
            w_rem_nxt   = '0;
            w_state_nxt = CALC;
          end
        end
      end
      CALC: begin
        w_pr_nxt  = w_step_pr;
        w_d_nxt   = {r_d[DIVISOR_W-2:0], 1'b0};
        w_q_nxt   = w_q_shift;
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == LastCnt) begin
          w_state_nxt = DONE;
`ifdef APPROX_DIV_TRUNC_EN
          w_q_nxt     = w_q_shift << TRUNC_BITS;
          w_rem_nxt   = '0;
`else
          w_rem_nxt   = w_step_pr[DIVISOR_W-1:0];
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          w_ovf_nxt   = 1'b0;
          w_dbz_nxt   = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pr    <= '0;
      r_d     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_q     <= '0;
      r_rem   <= '0;
      r_ovf   <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pr    <= w_pr_nxt;
      r_d     <= w_d_nxt;
      r_b     <= w_b_nxt;
      r_cnt   <= w_cnt_nxt;
      r_q     <= w_q_nxt;
      r_rem   <= w_rem_nxt;
      r_ovf   <= w_ovf_nxt;
      r_dbz   <= w_dbz_nxt;
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign Q         = r_q;
  assign REM       = r_rem;
  assign ovf       = r_ovf;
  assign dbz       = r_dbz;

endmodule

// File: tb/tb_approx_div_16x8_seq.sv
// Scoreboard bench for approx_div_16x8_seq: the driver pushes model results into a queue,
// the monitor pops and compares whenever the divider presents out_valid.
module tb_approx_div_16x8_seq;

  localparam int unsigned TB_TRUNC = 2;
`ifdef APPROX_DIV_TRUNC_EN
  localparam int NIT = 8 - TB_TRUNC;
`else
  localparam int NIT = 8;
`endif

  typedef struct {
    logic [15:0] r;
    logic [7:0]  b;
    logic [7:0]  q;
    logic [7:0]  rem;
    logic        ovf;
    logic        dbz;
    longint      lat;
    longint      acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] r_in = '0;
  logic [7:0]  b_in = '0;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  q_out;
  logic [7:0]  rem_out;
  logic        ovf_out;
  logic        dbz_out;

  int     n_checks = 0;
  int     n_fail = 0;
  longint cyc = 0;
  exp_t   q_exp[$];
  exp_t   cur;
  bit     have_cur = 1'b0;
  bit     bp_rand = 1'b0;
  bit     or_hold = 1'b1;

  approx_div_16x8_seq #(.TRUNC_BITS(TB_TRUNC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .R         (r_in),
    .B         (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Q         (q_out),
    .REM       (rem_out),
    .ovf       (ovf_out),
    .dbz       (dbz_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division with the divider's overflow/zero conventions.
  function automatic exp_t model(input logic [15:0] r, input logic [7:0] b);
    exp_t        e;
    int unsigned quo;
    e.r = r; e.b = b; e.ovf = 1'b0; e.dbz = 1'b0; e.acc = 0; e.rem = '0;
    if (b == 8'd0) begin
      e.q = 8'hFF; e.rem = r[7:0]; e.dbz = 1'b1; e.lat = 1;
    end else begin
      quo = 32'(r) / 32'(b);
      if (quo > 255) begin
        e.q = 8'hFF; e.rem = 8'd0; e.ovf = 1'b1; e.lat = 1;
      end else begin
`ifdef APPROX_DIV_TRUNC_EN
        quo   = (quo >> TB_TRUNC) << TB_TRUNC;
        e.rem = 8'd0;
`else
        e.rem = 8'(32'(r) % 32'(b));
`endif
        e.q   = 8'(quo);
        e.lat = 1 + NIT;
      end
    end
    return e;
  endfunction

  // out_ready changes just after the rising edge so both sides see a stable value.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp_rand ? ($urandom_range(3, 0) != 0) : or_hold;
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      have_cur = 1'b0;
    end else if (out_valid) begin
      if (!have_cur) begin
        if (q_exp.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_valid: out_valid=1 with no request outstanding (cycle %0d)",
                   cyc);
        end else begin
          cur      = q_exp.pop_front();
          have_cur = 1'b1;
          chk("latency", cyc - cur.acc, cur.lat);
`ifndef APPROX_DIV_TRUNC_EN
          if (!cur.ovf && !cur.dbz) begin
            chk("identity_qb_plus_rem", longint'(q_out) * longint'(cur.b) + longint'(rem_out),
                longint'(cur.r));
            chk("rem_lt_b", longint'(rem_out < cur.b), 1);
          end
`endif
        end
      end
      if (have_cur) begin
        chk("q", q_out, cur.q);
        chk("rem", rem_out, cur.rem);
        chk("ovf", ovf_out, cur.ovf);
        chk("dbz", dbz_out, cur.dbz);
        chk("in_ready_while_done", in_ready, 0);
        if (out_ready) have_cur = 1'b0;
      end
    end
  end

  task automatic issue(input logic [15:0] r, input logic [7:0] b);
    int   w;
    exp_t e;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready_before_issue", in_ready, 1);
    if (!in_ready) return;
    in_valid = 1'b1;
    r_in     = r;
    b_in     = b;
    e        = model(r, b);
    e.acc    = cyc;
    q_exp.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    r_in     = 16'($urandom);
    b_in     = 8'($urandom);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((q_exp.size() != 0 || have_cur) && w < 500) begin
      @(negedge clk);
      w++;
    end
    chk("drain_outstanding", longint'(q_exp.size()) + longint'(have_cur), 0);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] hi, lo, bb;
    int         w;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_q", q_out, 0);
    chk("rst_rem", rem_out, 0);
    chk("rst_ovf", ovf_out, 0);
    chk("rst_dbz", dbz_out, 0);
    rst_n = 1'b1;

    issue(16'd15129, 8'd123);
    issue(16'd1000, 8'd7);
    issue(16'h8000, 8'h10);
    issue(16'd500, 8'd0);
    drain();

    // Back-pressure: result must hold while in_valid pulses are ignored.
    or_hold = 1'b0;
    repeat (2) @(posedge clk);
    issue(16'd255, 8'd1);
    w = 0;
    while (!out_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("bp_valid_seen", out_valid, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = i[0];
      r_in     = 16'($urandom);
      b_in     = 8'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0;
    or_hold  = 1'b1;
    drain();

    // Reset in the middle of CALC discards the pending result.
    issue(16'd2000, 8'd77);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midcalc_rst_out_valid", out_valid, 0);
    chk("midcalc_rst_in_ready", in_ready, 1);
    q_exp.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(16'd100, 8'd9);
    drain();

    // Random in-range sweep, second half with random back-pressure.
    for (int i = 0; i < 2400; i++) begin
      if (i == 1200) bp_rand = 1'b1;
      bb = 8'($urandom_range(255, 1));
      hi = 8'($urandom_range(32'(bb) - 1, 0));
      lo = 8'($urandom);
      issue({hi, lo}, bb);
    end
    // Unrestricted operands, including overflow and zero divisors.
    for (int i = 0; i < 300; i++) begin
      bb = (i % 10 == 0) ? 8'd0 : 8'($urandom);
      issue(16'($urandom), bb);
    end
    bp_rand = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
